// File: rtl/decode_cycle.sv
// decode_cycle
//
// Second stage of the RV32I pipeline, directly after fetch. It decodes the
// fetched instruction and registers the result for execute: register
// indices, funct3, the sign-extended immediate, the instruction class, the
// ALU operation and an illegal-encoding flag. It also detects load-use
// hazards, which cost one bubble while fetch is held.
//
// Ports
//   clk          clock; every register updates on the rising edge
//   reset_n      asynchronous active-low reset
//   i_ce         fetch slot valid
//   i_inst       instruction word from fetch
//   i_pc         PC of i_inst
//   i_stall      downstream stall; all registers hold
//   i_flush      taken branch/jump; the slot is killed
//   o_stall      stall to fetch (i_stall or load-use hazard)
//   o_flush      flush to fetch (equals i_flush)
//   o_ce         decoded slot valid
//   o_pc         PC of the decoded instruction
//   o_rs1_addr   rs1 index
//   o_rs2_addr   rs2 index
//   o_rd_addr    rd index
//   o_funct3     inst[14:12]
//   o_imm        sign-extended immediate
//   o_opcode     one-hot class: LUI AUIPC JAL JALR BRANCH LOAD STORE
//                OP_IMM OP FENCE SYSTEM (bit 0 upwards)
//   o_alu        one-hot ALU op: ADD SUB SLT SLTU XOR OR AND SLL SRL SRA
//                EQ NEQ GE GEU (bit 0 upwards)
//   o_illegal    unsupported encoding, meaningful while o_ce is high
module decode_cycle #(
    parameter logic [31:0] PC_RESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_ce,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_flush,
    output logic        o_ce,
    output logic [31:0] o_pc,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    output logic [4:0]  o_rd_addr,
    output logic [2:0]  o_funct3,
    output logic [31:0] o_imm,
    output logic [10:0] o_opcode,
    output logic [13:0] o_alu,
    output logic        o_illegal
);

    // Instruction class bit positions in o_opcode.
    localparam int C_LUI    = 0;
    localparam int C_AUIPC  = 1;
    localparam int C_JAL    = 2;
    localparam int C_JALR   = 3;
    localparam int C_BRANCH = 4;
    localparam int C_LOAD   = 5;
    localparam int C_STORE  = 6;
    localparam int C_OP_IMM = 7;
    localparam int C_OP     = 8;
    localparam int C_FENCE  = 9;
    localparam int C_SYSTEM = 10;

    // ALU operation bit positions in o_alu.
    localparam int A_ADD  = 0;
    localparam int A_SUB  = 1;
    localparam int A_SLT  = 2;
    localparam int A_SLTU = 3;
    localparam int A_XOR  = 4;
    localparam int A_OR   = 5;
    localparam int A_AND  = 6;
    localparam int A_SLL  = 7;
    localparam int A_SRL  = 8;
    localparam int A_SRA  = 9;
    localparam int A_EQ   = 10;
    localparam int A_NEQ  = 11;
    localparam int A_GE   = 12;
    localparam int A_GEU  = 13;

    // Classes that read rs1 / rs2.
    localparam logic [10:0] USES_RS1_MASK = 11'h1F8; // JALR BRANCH LOAD STORE OP_IMM OP
    localparam logic [10:0] USES_RS2_MASK = 11'h150; // BRANCH STORE OP

    // Integer ALU op selected by funct3; alt picks SUB/SRA over ADD/SRL.
    function automatic logic [13:0] alu_arith(input logic [2:0] f3, input logic alt);
        logic [13:0] a;
        a = '0;
        case (f3)
            3'b000:  a[alt ? A_SUB : A_ADD] = 1'b1;
            3'b001:  a[A_SLL] = 1'b1;
            3'b010:  a[A_SLT] = 1'b1;
            3'b011:  a[A_SLTU] = 1'b1;
            3'b100:  a[A_XOR] = 1'b1;
            3'b101:  a[alt ? A_SRA : A_SRL] = 1'b1;
            3'b110:  a[A_OR] = 1'b1;
            default: a[A_AND] = 1'b1;
        endcase
        return a;
    endfunction

    // ---- stage p0: combinational decode of the fetch slot ----
    logic [2:0]  funct3_p0;
    logic [6:0]  funct7_p0;
    logic [31:0] imm_i_p0, imm_s_p0, imm_b_p0, imm_u_p0, imm_j_p0;
    logic [31:0] imm_p0;
    logic [10:0] opc_p0;
    logic [13:0] alu_p0;
    logic        ill_p0;
    logic        uses_rs1_p0, uses_rs2_p0;
    logic        hazard;

    assign funct3_p0 = i_inst[14:12];
    assign funct7_p0 = i_inst[31:25];

    assign imm_i_p0 = {{20{i_inst[31]}}, i_inst[31:20]};
    assign imm_s_p0 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_b_p0 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign imm_u_p0 = {i_inst[31:12], 12'b0};
    assign imm_j_p0 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    always_comb begin
        opc_p0 = '0;
        alu_p0 = '0;
        alu_p0[A_ADD] = 1'b1;
        imm_p0 = '0;
        ill_p0 = 1'b0;
        if (i_inst[1:0] != 2'b11) begin
            ill_p0 = 1'b1;
        end else begin
            case (i_inst[6:2])
                5'b01101: begin
                    opc_p0[C_LUI] = 1'b1;
                    imm_p0 = imm_u_p0;
                end
                5'b00101: begin
                    opc_p0[C_AUIPC] = 1'b1;
                    imm_p0 = imm_u_p0;
                end
                5'b11011: begin
                    opc_p0[C_JAL] = 1'b1;
                    imm_p0 = imm_j_p0;
                end
                5'b11001: begin
                    opc_p0[C_JALR] = 1'b1;
                    imm_p0 = imm_i_p0;
                    ill_p0 = (funct3_p0 != 3'b000);
                end
                5'b11000: begin
                    opc_p0[C_BRANCH] = 1'b1;
                    imm_p0 = imm_b_p0;
                    alu_p0 = '0;
                    case (funct3_p0)
                        3'b000:  alu_p0[A_EQ] = 1'b1;
                        3'b001:  alu_p0[A_NEQ] = 1'b1;
                        3'b100:  alu_p0[A_SLT] = 1'b1;
                        3'b101:  alu_p0[A_GE] = 1'b1;
                        3'b110:  alu_p0[A_SLTU] = 1'b1;
                        3'b111:  alu_p0[A_GEU] = 1'b1;
                        default: ill_p0 = 1'b1;
                    endcase
                end
                5'b00000: begin
                    opc_p0[C_LOAD] = 1'b1;
                    imm_p0 = imm_i_p0;
                    ill_p0 = (funct3_p0 == 3'b011) || (funct3_p0 == 3'b110) || (funct3_p0 == 3'b111);
                end
                5'b01000: begin
                    opc_p0[C_STORE] = 1'b1;
                    imm_p0 = imm_s_p0;
                    ill_p0 = (funct3_p0 >= 3'b011);
                end
                5'b00100: begin
                    opc_p0[C_OP_IMM] = 1'b1;
                    imm_p0 = imm_i_p0;
                    // Only the right-shift immediate has an alternate form.
                    alu_p0 = alu_arith(funct3_p0, (funct3_p0 == 3'b101) && (funct7_p0 == 7'h20));
                    if (funct3_p0 == 3'b001)
                        ill_p0 = (funct7_p0 != 7'h00);
                    else if (funct3_p0 == 3'b101)
                        ill_p0 = (funct7_p0 != 7'h00) && (funct7_p0 != 7'h20);
                end
                5'b01100: begin
                    opc_p0[C_OP] = 1'b1;
                    alu_p0 = alu_arith(funct3_p0, funct7_p0 == 7'h20);
                    if ((funct7_p0 != 7'h00) && (funct7_p0 != 7'h20))
                        ill_p0 = 1'b1;
                    else if ((funct7_p0 == 7'h20) && (funct3_p0 != 3'b000) && (funct3_p0 != 3'b101))
                        ill_p0 = 1'b1;
                end
                5'b00011: opc_p0[C_FENCE] = 1'b1;
                5'b11100: opc_p0[C_SYSTEM] = 1'b1;
                default:  ill_p0 = 1'b1;
            endcase
        end
        // An illegal word carries no class and a harmless ADD.
        if (ill_p0) begin
            opc_p0 = '0;
            alu_p0 = '0;
            alu_p0[A_ADD] = 1'b1;
        end
    end

    assign uses_rs1_p0 = |(opc_p0 & USES_RS1_MASK);
    assign uses_rs2_p0 = |(opc_p0 & USES_RS2_MASK);

    // A load sitting in the output slot whose rd is read by the incoming
    // instruction: execute cannot forward load data yet, so insert a bubble.
    assign hazard = o_ce & o_opcode[C_LOAD] & (o_rd_addr != 5'd0) & i_ce &
                    ((uses_rs1_p0 & (i_inst[19:15] == o_rd_addr)) |
                     (uses_rs2_p0 & (i_inst[24:20] == o_rd_addr)));

    assign o_stall = i_stall | hazard;
    assign o_flush = i_flush;

    // ---- stage p1: registered slot presented to execute ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_ce       <= 1'b0;
            o_pc       <= PC_RESET;
            o_rs1_addr <= '0;
            o_rs2_addr <= '0;
            o_rd_addr  <= '0;
            o_funct3   <= '0;
            o_imm      <= '0;
            o_opcode   <= '0;
            o_alu      <= '0;
            o_illegal  <= 1'b0;
        end else if (i_flush) begin
            o_ce <= 1'b0;
        end else if (i_stall) begin
            o_ce <= o_ce;
        end else if (hazard) begin
            // Bubble: the held fields stay, and with o_ce low the hazard
            // drops next cycle so the stalled instruction loads.
            o_ce <= 1'b0;
        end else begin
            o_ce       <= i_ce;
            o_pc       <= i_pc;
            o_rs1_addr <= i_inst[19:15];
            o_rs2_addr <= i_inst[24:20];
            o_rd_addr  <= i_inst[11:7];
            o_funct3   <= funct3_p0;
            o_imm      <= imm_p0;
            o_opcode   <= opc_p0;
            o_alu      <= alu_p0;
            o_illegal  <= ill_p0;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_ce;
    logic [31:0] i_inst;
    logic [31:0] i_pc;
    logic        i_stall;
    logic        i_flush;
    logic        o_stall;
    logic        o_flush;
    logic        o_ce;
    logic [31:0] o_pc;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic [4:0]  o_rd_addr;
    logic [2:0]  o_funct3;
    logic [31:0] o_imm;
    logic [10:0] o_opcode;
    logic [13:0] o_alu;
    logic        o_illegal;

    decode_cycle #(.PC_RESET(32'd0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_ce       (i_ce),
        .i_inst     (i_inst),
        .i_pc       (i_pc),
        .i_stall    (i_stall),
        .i_flush    (i_flush),
        .o_stall    (o_stall),
        .o_flush    (o_flush),
        .o_ce       (o_ce),
        .o_pc       (o_pc),
        .o_rs1_addr (o_rs1_addr),
        .o_rs2_addr (o_rs2_addr),
        .o_rd_addr  (o_rd_addr),
        .o_funct3   (o_funct3),
        .o_imm      (o_imm),
        .o_opcode   (o_opcode),
        .o_alu      (o_alu),
        .o_illegal  (o_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [10:0] opc;
        logic [13:0] alu;
        logic        ill;
        logic        u1;
        logic        u2;
    } dec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state of the output slot.
    logic        m_ce;
    logic [31:0] m_pc;
    dec_t        m_d;
    logic        m_known;
    logic        last_stall_obs;
    logic        last_stall_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Decode from the instruction-set rules, using whole 7-bit opcodes and
    // integer arithmetic for the immediates.
    function automatic dec_t ref_dec(input logic [31:0] x);
        dec_t d;
        int cls, s, t, r;
        int arith[8];
        int br[8];
        logic [2:0] f3;
        logic [6:0] f7;
        arith = '{0, 7, 2, 3, 4, 8, 5, 6};
        br    = '{10, 11, -1, -1, 2, 12, 3, 13};
        f3 = x[14:12];
        f7 = x[31:25];
        case (x[6:0])
            7'h37: cls = 0;
            7'h17: cls = 1;
            7'h6F: cls = 2;
            7'h67: cls = 3;
            7'h63: cls = 4;
            7'h03: cls = 5;
            7'h23: cls = 6;
            7'h13: cls = 7;
            7'h33: cls = 8;
            7'h0F: cls = 9;
            7'h73: cls = 10;
            default: cls = -1;
        endcase
        d = '0;
        d.rs1 = x[19:15];
        d.rs2 = x[24:20];
        d.rd  = x[11:7];
        d.f3  = f3;
        s = x;
        r = 0;
        case (cls)
            0, 1: r = x & 32'hFFFFF000;
            2: begin
                t = s >>> 31;
                r = t * 1048576 + int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
            end
            3, 5, 7: r = s >>> 20;
            4: begin
                t = s >>> 31;
                r = t * 4096 + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
            end
            6: begin
                t = s >>> 25;
                r = t * 32 + int'(x[11:7]);
            end
            default: r = 0;
        endcase
        d.imm = r;
        case (cls)
            -1: d.ill = 1'b1;
            3:  d.ill = (f3 != 0);
            4:  d.ill = (br[f3] < 0);
            5:  d.ill = (f3 == 3) || (f3 >= 6);
            6:  d.ill = (f3 >= 3);
            7:  d.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 7'h20));
            8:  d.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            default: d.ill = 1'b0;
        endcase
        if (d.ill) begin
            d.opc = '0;
            d.alu = 14'd1;
        end else begin
            d.opc = 11'd1 << cls;
            t = 0;
            if (cls == 7 || cls == 8) begin
                t = arith[f3];
                if (f3 == 5 && f7 == 7'h20) t = 9;
                if (cls == 8 && f3 == 0 && f7 == 7'h20) t = 1;
            end else if (cls == 4) begin
                t = br[f3];
            end
            d.alu = 14'd1 << t;
            d.u1 = (cls >= 3 && cls <= 8);
            d.u2 = (cls == 4 || cls == 6 || cls == 8);
        end
        return d;
    endfunction

    task automatic model_reset();
        m_ce = 1'b0;
        m_pc = 32'd0;
        m_d = '0;
        m_known = 1'b1;
        last_stall_exp = 1'b0;
    endtask

    task automatic check_slot();
        chk("o_ce", {31'b0, o_ce}, {31'b0, m_ce});
        if (m_known) begin
            chk("o_pc", o_pc, m_pc);
            chk("o_rs1", {27'b0, o_rs1_addr}, {27'b0, m_d.rs1});
            chk("o_rs2", {27'b0, o_rs2_addr}, {27'b0, m_d.rs2});
            chk("o_rd", {27'b0, o_rd_addr}, {27'b0, m_d.rd});
            chk("o_funct3", {29'b0, o_funct3}, {29'b0, m_d.f3});
            chk("o_opcode", {21'b0, o_opcode}, {21'b0, m_d.opc});
            chk("o_alu", {18'b0, o_alu}, {18'b0, m_d.alu});
            chk("o_illegal", {31'b0, o_illegal}, {31'b0, m_d.ill});
            if (!m_d.ill) chk("o_imm", o_imm, m_d.imm);
        end
    endtask

    // One clock: drive, check the combinational feedback, clock, check slot.
    task automatic step(input logic ce, input logic [31:0] inst, input logic [31:0] pc,
                        input logic stl, input logic fl);
        dec_t d;
        logic hz;
        i_ce = ce;
        i_inst = inst;
        i_pc = pc;
        i_stall = stl;
        i_flush = fl;
        #1;
        d = ref_dec(inst);
        hz = m_ce && m_d.opc[5] && (m_d.rd != 0) && ce &&
             ((d.u1 && inst[19:15] == m_d.rd) || (d.u2 && inst[24:20] == m_d.rd));
        last_stall_obs = o_stall;
        last_stall_exp = stl | hz;
        chk("o_stall", {31'b0, o_stall}, {31'b0, stl | hz});
        chk("o_flush", {31'b0, o_flush}, {31'b0, fl});
        @(posedge clk);
        if (fl) begin
            m_ce = 1'b0;
        end else if (stl) begin
            m_ce = m_ce;
        end else if (hz) begin
            m_ce = 1'b0;
        end else begin
            m_ce = ce;
            m_pc = pc;
            m_d = d;
            m_known = ce;
        end
        #1;
        check_slot();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ce"}, {31'b0, o_ce}, 32'd0);
        chk({tag, "_pc"}, o_pc, 32'd0);
        chk({tag, "_imm"}, o_imm, 32'd0);
        chk({tag, "_opcode"}, {21'b0, o_opcode}, 32'd0);
        chk({tag, "_alu"}, {18'b0, o_alu}, 32'd0);
        chk({tag, "_regs"}, {17'b0, o_rs1_addr, o_rs2_addr, o_rd_addr}, 32'd0);
        chk({tag, "_funct3"}, {29'b0, o_funct3}, 32'd0);
        chk({tag, "_illegal"}, {31'b0, o_illegal}, 32'd0);
        chk({tag, "_stall"}, {31'b0, o_stall}, 32'd0);
    endtask

    initial begin
        logic [6:0]  ops[11];
        logic [31:0] x, pc, h_inst, h_pc;
        logic        ce, stl, fl, h_ce;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

        reset_n = 1'b0;
        i_ce = 1'b0;
        i_inst = 32'd0;
        i_pc = 32'd0;
        i_stall = 1'b0;
        i_flush = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        #6;
        reset_n = 1'b1;

        // addi x1,x0,5
        step(1'b1, 32'h00500093, 32'h10, 1'b0, 1'b0);
        chk("addi_ce", {31'b0, o_ce}, 32'd1);
        chk("addi_rd", {27'b0, o_rd_addr}, 32'd1);
        chk("addi_imm", o_imm, 32'd5);
        chk("addi_opcode", {21'b0, o_opcode}, 32'h080);
        chk("addi_alu", {18'b0, o_alu}, 32'h1);
        chk("addi_pc", o_pc, 32'h10);

        // beq x1,x2,-4
        step(1'b1, 32'hFE208EE3, 32'h14, 1'b0, 1'b0);
        chk("beq_imm", o_imm, 32'hFFFFFFFC);
        chk("beq_opcode", {21'b0, o_opcode}, 32'h010);
        chk("beq_alu", {18'b0, o_alu}, 32'h400);

        // lw x5,0(x2) then add x6,x5,x1: one bubble
        step(1'b1, 32'h00012283, 32'h18, 1'b0, 1'b0);
        step(1'b1, 32'h00128333, 32'h1C, 1'b0, 1'b0);
        chk("lu_stall", {31'b0, last_stall_obs}, 32'd1);
        chk("lu_bubble", {31'b0, o_ce}, 32'd0);
        step(1'b1, 32'h00128333, 32'h1C, 1'b0, 1'b0);
        chk("lu_stall_clear", {31'b0, last_stall_obs}, 32'd0);
        chk("lu_issue_ce", {31'b0, o_ce}, 32'd1);
        chk("lu_issue_rd", {27'b0, o_rd_addr}, 32'd6);
        chk("lu_issue_alu", {18'b0, o_alu}, 32'h1);

        // lw x0 then a dependent-looking add: no bubble
        step(1'b1, 32'h00012003, 32'h20, 1'b0, 1'b0);
        step(1'b1, 32'h00128333, 32'h24, 1'b0, 1'b0);
        chk("x0_no_stall", {31'b0, last_stall_obs}, 32'd0);
        chk("x0_issue_ce", {31'b0, o_ce}, 32'd1);

        // Three stalled cycles then a flush while stalled
        step(1'b1, 32'h00500093, 32'h30, 1'b1, 1'b0);
        step(1'b1, 32'h00500093, 32'h30, 1'b1, 1'b0);
        step(1'b1, 32'h00500093, 32'h30, 1'b1, 1'b0);
        chk("stall_pc_held", o_pc, 32'h24);
        step(1'b1, 32'h00500093, 32'h30, 1'b1, 1'b1);
        chk("flush_ce", {31'b0, o_ce}, 32'd0);

        // Illegal encodings
        step(1'b1, 32'hFFFFFFFF, 32'h40, 1'b0, 1'b0);
        chk("ill_ff_flag", {31'b0, o_illegal}, 32'd1);
        chk("ill_ff_opcode", {21'b0, o_opcode}, 32'd0);
        chk("ill_ff_ce", {31'b0, o_ce}, 32'd1);
        step(1'b1, 32'h02208033, 32'h44, 1'b0, 1'b0);
        chk("ill_f7_flag", {31'b0, o_illegal}, 32'd1);
        chk("ill_f7_opcode", {21'b0, o_opcode}, 32'd0);
        chk("ill_f7_alu", {18'b0, o_alu}, 32'h1);

        // Asynchronous reset in the middle of traffic
        step(1'b1, 32'h00500093, 32'h50, 1'b0, 1'b0);
        i_stall = 1'b0;
        i_flush = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic; fetch holds its slot while o_stall is high
        h_ce = 1'b0;
        h_inst = 32'd0;
        h_pc = 32'd0;
        for (int n = 0; n < 400; n++) begin
            x = $urandom;
            x[11:7]  = 5'($urandom_range(0, 3));
            x[19:15] = 5'($urandom_range(0, 3));
            x[24:20] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 15) != 0) begin
                if ($urandom_range(0, 3) == 0)
                    x[6:0] = 7'h03;
                else
                    x[6:0] = ops[$urandom_range(0, 10)];
                if (x[6:0] == 7'h33 || (x[6:0] == 7'h13 && x[13:12] == 2'b01)) begin
                    case ($urandom_range(0, 3))
                        0, 1:    x[31:25] = 7'h00;
                        2:       x[31:25] = 7'h20;
                        default: x[31:25] = 7'($urandom);
                    endcase
                end
            end
            pc = $urandom & 32'hFFFFFFFC;
            ce = ($urandom_range(0, 7) != 0);
            stl = ($urandom_range(0, 5) == 0);
            fl = ($urandom_range(0, 9) == 0);
            if (last_stall_exp) begin
                ce = h_ce;
                x = h_inst;
                pc = h_pc;
            end
            h_ce = ce;
            h_inst = x;
            h_pc = pc;
            step(ce, x, pc, stl, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second pipeline stage of the RV32I core, directly downstream of the fetch stage. Takes the fetched instruction word and PC with their valid (`ce`) flag, and decodes fields, immediate, instruction class and ALU operation into a registered pipeline slot for execute. Detects load-use hazards and inserts one bubble, holding the fetch stage meanwhile. Propagates the downstream stall and branch flush back to fetch.

## Interface
- `PC_RESET`, 32'd0, value of `o_pc` after reset.
- `clk`  in  1  clock; all registers update on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_ce`  in  1  fetch slot valid.
- `i_inst`  in  32  instruction word from fetch.
- `i_pc`  in  32  PC of `i_inst`.
- `i_stall`  in  1  downstream stall; this stage holds its outputs.
- `i_flush`  in  1  taken branch/jump from ALU; kill the slot.
- `o_stall`  out  1  stall to fetch: `i_stall | hazard`.
- `o_flush`  out  1  flush to fetch: equals `i_flush`.
- `o_ce`  out  1  decoded slot valid.
- `o_pc`  out  32  PC of decoded instruction.
- `o_rs1_addr`, `o_rs2_addr`, `o_rd_addr`  out  5 each  register indices.
- `o_funct3`  out  3  `inst[14:12]`.
- `o_imm`  out  32  sign-extended immediate.
- `o_opcode`  out  11  one-hot: [0]LUI [1]AUIPC [2]JAL [3]JALR [4]BRANCH [5]LOAD [6]STORE [7]OP_IMM [8]OP [9]FENCE [10]SYSTEM.
- `o_alu`  out  14  one-hot: [0]ADD [1]SUB [2]SLT [3]SLTU [4]XOR [5]OR [6]AND [7]SLL [8]SRL [9]SRA [10]EQ [11]NEQ [12]GE [13]GEU.
- `o_illegal`  out  1  unsupported encoding; qualified by `o_ce`.

## Operation
- Decode is combinational from `i_inst`; all `o_*` except `o_stall`/`o_flush` are registers.
- Immediate: I `{{20{i[31]}},i[31:20]}`; S `i[31:25],i[11:7]`; B `i[31],i[7],i[30:25],i[11:8],0`; U `i[31:12],12'b0`; J `i[31],i[19:12],i[20],i[30:21],0`; all sign-extended from bit 31. R-type, FENCE, SYSTEM: 0.
- ALU op: OP/OP_IMM from funct3 (SUB only for OP with funct7=0x20; SRA for funct7=0x20 on funct3=101). BRANCH: BEQ→EQ, BNE→NEQ, BLT→SLT, BGE→GE, BLTU→SLTU, BGEU→GEU. LUI, AUIPC, JAL, JALR, LOAD, STORE, FENCE, SYSTEM → ADD.
- Illegal (sets `o_illegal`, `o_opcode`=0, `o_alu`=ADD): `inst[1:0]`≠11, unknown opcode, funct7∉{0x00,0x20} for OP, funct7=0x20 on OP funct3∉{000,101}, shift-imm funct7 not 0x00/0x20 (0x20 only for SRAI), bad funct3 on BRANCH (010/011), LOAD (011/110/111), STORE (≥011), JALR (≠000).
- Hazard: `hazard = o_ce & o_opcode[5] & (o_rd_addr≠0) & i_ce & ((uses_rs1 & rs1==o_rd_addr) | (uses_rs2 & rs2==o_rd_addr))`. `uses_rs1`: all but LUI/AUIPC/JAL/FENCE/SYSTEM. `uses_rs2`: BRANCH/STORE/OP.
- Upstream must hold `i_inst/i_pc/i_ce` while `o_stall`=1.

## Timing
- Reset (async, `reset_n`=0): `o_ce`=0, `o_pc`=PC_RESET, all other registered outputs 0; `o_stall`=`o_flush`=0 absent inputs.
- Latency 1 cycle: input accepted on edge N appears on outputs after edge N.
- Per-edge priority: (1) `i_flush`: `o_ce`←0, other fields hold; overrides `i_stall` and hazard. (2) `i_stall`: all registers hold. (3) hazard: `o_ce`←0 (bubble), fields hold; next cycle `o_ce`=0 so hazard clears and the held instruction loads. (4) else: load decode, `o_ce`←`i_ce`.
- `i_ce`=0 with no stall: `o_ce`←0, fields may update (don't-care).
- Hazard costs exactly one bubble; back-to-back loads each checked independently.
- Reset deasserted mid-stream: first accepted slot is whatever fetch presents after release.

## Test plan
- Reset: `reset_n`=0 mid-transfer → all outputs zero, `o_pc`=0, `o_ce`=0 immediately (asynchronous).
- `0x00500093` (addi x1,x0,5), `i_pc`=0x10 → next cycle `o_ce`=1, rd=1, rs1=0, imm=5, `o_opcode[7]`, `o_alu[0]`, `o_pc`=0x10.
- `0xFE208EE3` (beq x1,x2,-4) → `o_imm`=0xFFFFFFFC, rs1=1, rs2=2, `o_opcode[4]`, `o_alu[10]`.
- `0x00012283` (lw x5,0(x2)) then `0x00128333` (add x6,x5,x1) → `o_stall`=1 for one cycle, one `o_ce`=0 bubble, then add issues with rd=6, `o_alu[0]`; repeat with rd=x0 load → no bubble.
- `i_stall`=1 for 3 cycles → outputs constant, `o_stall`=1; `i_flush` during stall → `o_ce`=0 next edge, `o_flush`=1 same cycle.
- `0xFFFFFFFF` and `0x02208033` (funct7=0x01) → `o_illegal`=1, `o_opcode`=0, `o_ce`=1.
